// File: rtl/clock_pkg.sv
// Shared field indices and FSM state encoding for the clock/calendar set controller.
package clock_pkg;

    localparam int FLD_SEC  = 0;
    localparam int FLD_MIN  = 1;
    localparam int FLD_HOUR = 2;
    localparam int FLD_DAY  = 3;
    localparam int FLD_MON  = 4;
    localparam int FLD_YEAR = 5;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_EDIT = 1'b1
    } state_e;

endpackage

// File: rtl/clock_set_ctrl_btn_repeat.sv
// Rising-edge detector with hold-to-repeat for one debounced button.
// Emits a combinational pulse on the rise and on every auto-repeat; the caller registers it.
module btn_repeat #(
    parameter int REPEAT_DLY = 8,
    parameter int REPEAT_PER = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    input  logic clr,
    output logic rise,
    output logic pulse
);

    localparam int                CNT_W      = $clog2(REPEAT_DLY + 1);
    localparam logic [CNT_W-1:0]  CNT_DLY    = CNT_W'(REPEAT_DLY);
    // Reloading here puts the next hit exactly REPEAT_PER cycles later (needs REPEAT_PER <= REPEAT_DLY).
    localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(REPEAT_DLY - REPEAT_PER + 1);

    logic             btn_q;
    logic             btn_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Edge detect and hold counter next-state.
    always_comb begin
        btn_d = btn;
        rise  = btn & ~btn_q;
        pulse = 1'b0;
        cnt_d = '0;
        if (clr || !btn) begin
            pulse = 1'b0;
            cnt_d = '0;
        end else if (rise) begin
            pulse = 1'b1;
            cnt_d = CNT_W'(1);
        end else if (cnt_q == CNT_DLY) begin
            pulse = 1'b1;
            cnt_d = CNT_RELOAD;
        end else begin
            pulse = 1'b0;
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Edge register resets high so a button held through reset gives no edge until released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_q <= 1'b1;
            cnt_q <= '0;
        end else begin
            btn_q <= btn_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/clock_set_ctrl.sv
// Sequencer for the clock/calendar field counters: ripple-carry ticks in RUN,
// cursor-driven inc/dec with auto-repeat and inactivity timeout in EDIT.
module clock_set_ctrl
    import clock_pkg::*;
#(
    parameter int NUM_FIELDS    = 6,
    parameter int SEL_W         = 3,
    parameter int TIMEOUT_TICKS = 10,
    parameter int REPEAT_DLY    = 8,
    parameter int REPEAT_PER    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick_1hz,
    input  logic                  btn_mode,
    input  logic                  btn_up,
    input  logic                  btn_down,
    input  logic [NUM_FIELDS-1:0] at_max,
    output logic [NUM_FIELDS-1:0] inc,
    output logic [NUM_FIELDS-1:0] dec,
    output logic                  edit,
    output logic [SEL_W-1:0]      sel,
    output logic                  blink
);

    localparam int               TO_W     = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_TICKS - 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_FIELDS - 1);

    state_e                state_q, state_d;
    logic [SEL_W-1:0]      sel_q, sel_d;
    logic [TO_W-1:0]       to_q, to_d;
    logic                  blink_q, blink_d;
    logic                  mode_q, mode_d;
    logic [NUM_FIELDS-1:0] inc_q, inc_d;
    logic [NUM_FIELDS-1:0] dec_q, dec_d;

    logic mode_rise;
    logic up_rise, up_pulse;
    logic down_rise, down_pulse;
    logic rpt_clr;
    logic carry;

    assign mode_rise = btn_mode & ~mode_q;
    // Repeat counters only run for a single button held in EDIT.
    assign rpt_clr   = (btn_up & btn_down) | (state_q != ST_EDIT);

    btn_repeat #(
        .REPEAT_DLY (REPEAT_DLY),
        .REPEAT_PER (REPEAT_PER)
    ) u_rep_up (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_up),
        .clr   (rpt_clr),
        .rise  (up_rise),
        .pulse (up_pulse)
    );

    btn_repeat #(
        .REPEAT_DLY (REPEAT_DLY),
        .REPEAT_PER (REPEAT_PER)
    ) u_rep_down (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_down),
        .clr   (rpt_clr),
        .rise  (down_rise),
        .pulse (down_pulse)
    );

    // Mode FSM, cursor, timeout, blink and next output pulses.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        to_d    = to_q;
        blink_d = blink_q;
        mode_d  = btn_mode;
        inc_d   = '0;
        dec_d   = '0;
        carry   = 1'b1;
        case (state_q)
            ST_RUN: begin
                if (tick_1hz) begin
                    for (int k = 0; k < NUM_FIELDS; k++) begin
                        inc_d[k] = carry;
                        carry    = carry & at_max[k];
                    end
                end else begin
                    inc_d = '0;
                end
                if (mode_rise) begin
                    state_d = ST_EDIT;
                    sel_d   = '0;
                    to_d    = '0;
                    blink_d = 1'b0;
                end else begin
                    blink_d = 1'b0;
                end
            end
            ST_EDIT: begin
                if (tick_1hz) begin
                    blink_d = ~blink_q;
                end else begin
                    blink_d = blink_q;
                end
                if (mode_rise) begin
                    // Cursor advance wins; any up/down in this cycle is dropped.
                    blink_d = 1'b0;
                    to_d    = '0;
                    if (sel_q == SEL_LAST) begin
                        state_d = ST_RUN;
                        sel_d   = '0;
                    end else begin
                        sel_d = sel_q + SEL_W'(1);
                    end
                end else begin
                    if (up_pulse) begin
                        inc_d[sel_q] = 1'b1;
                    end else if (down_pulse) begin
                        dec_d[sel_q] = 1'b1;
                    end else begin
                        inc_d = '0;
                    end
                    if (up_rise || down_rise) begin
                        to_d = '0;
                    end else if (tick_1hz) begin
                        if (to_q == TO_LAST) begin
                            state_d = ST_RUN;
                            sel_d   = '0;
                            blink_d = 1'b0;
                            to_d    = '0;
                        end else begin
                            to_d = to_q + TO_W'(1);
                        end
                    end else begin
                        to_d = to_q;
                    end
                end
            end
            default: begin
                state_d = ST_RUN;
                sel_d   = '0;
                to_d    = '0;
                blink_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            sel_q   <= '0;
            to_q    <= '0;
            blink_q <= 1'b0;
            mode_q  <= 1'b1;
            inc_q   <= '0;
            dec_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            to_q    <= to_d;
            blink_q <= blink_d;
            mode_q  <= mode_d;
            inc_q   <= inc_d;
            dec_q   <= dec_d;
        end
    end

    assign inc   = inc_q;
    assign dec   = dec_q;
    assign edit  = (state_q == ST_EDIT);
    assign sel   = sel_q;
    assign blink = blink_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Scoreboard bench for clock_set_ctrl: directed scenarios plus randomized buttons/ticks
// against a behavioural model; a negedge monitor pops and compares every cycle.
module tb_clock_set_ctrl;

    localparam int NF = 6;
    localparam int SW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tick_1hz = 1'b0;
    logic          btn_mode = 1'b0;
    logic          btn_up = 1'b0;
    logic          btn_down = 1'b0;
    logic [NF-1:0] at_max = '0;
    logic [NF-1:0] inc;
    logic [NF-1:0] dec;
    logic          edit;
    logic [SW-1:0] sel;
    logic          blink;

    clock_set_ctrl #(
        .NUM_FIELDS    (NF),
        .SEL_W         (SW),
        .TIMEOUT_TICKS (10),
        .REPEAT_DLY    (8),
        .REPEAT_PER    (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .tick_1hz (tick_1hz),
        .btn_mode (btn_mode),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .at_max   (at_max),
        .inc      (inc),
        .dec      (dec),
        .edit     (edit),
        .sel      (sel),
        .blink    (blink)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NF-1:0] inc;
        logic [NF-1:0] dec;
        logic          edit;
        logic [SW-1:0] sel;
        logic          blink;
    } obs_t;

    obs_t exp_q[$];
    obs_t mon_e;
    obs_t mon_a;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    // Reference model state
    bit m_edit, m_blink;
    int m_sel, m_idle, up_run, dn_run;
    bit p_md, p_up, p_dn;

    // Random stimulus levels
    bit r_md, r_up, r_dn, r_tk;

    function automatic bit rep_fire(input int r, input bit rise_now);
        return (r == 0 && rise_now) || (r >= 8 && ((r - 8) % 4) == 0);
    endfunction

    task automatic model_reset();
        m_edit = 1'b0; m_blink = 1'b0; m_sel = 0; m_idle = 0;
        up_run = 0; dn_run = 0;
        p_md = 1'b1; p_up = 1'b1; p_dn = 1'b1;
    endtask

    task automatic model_step(input bit tk, input bit md, input bit up, input bit dn,
                              input logic [NF-1:0] am);
        bit   ur = up && !p_up;
        bit   dr = dn && !p_dn;
        bit   mr = md && !p_md;
        bit   clr = (up && dn) || !m_edit;
        bit   upp = 1'b0;
        bit   dnp = 1'b0;
        int   n;
        obs_t e;
        e = '0;
        if (up && !clr) begin upp = rep_fire(up_run, ur); up_run++; end
        else up_run = 0;
        if (dn && !clr) begin dnp = rep_fire(dn_run, dr); dn_run++; end
        else dn_run = 0;
        if (!m_edit) begin
            if (tk) begin
                n = 0;
                while (n < NF && am[n]) n++;
                e.inc = NF'((1 << (n + 1)) - 1);
            end
            if (mr) begin m_edit = 1'b1; m_sel = 0; m_idle = 0; m_blink = 1'b0; end
        end else begin
            if (tk) m_blink = !m_blink;
            if (mr) begin
                m_blink = 1'b0; m_idle = 0;
                if (m_sel == NF - 1) begin m_edit = 1'b0; m_sel = 0; end
                else m_sel++;
            end else begin
                if (upp) e.inc = NF'(1 << m_sel);
                else if (dnp) e.dec = NF'(1 << m_sel);
                if (ur || dr) m_idle = 0;
                else if (tk) begin
                    m_idle++;
                    if (m_idle == 10) begin
                        m_edit = 1'b0; m_sel = 0; m_blink = 1'b0; m_idle = 0;
                    end
                end
            end
        end
        p_md = md; p_up = up; p_dn = dn;
        e.edit = m_edit; e.sel = SW'(m_sel); e.blink = m_blink;
        exp_q.push_back(e);
    endtask

    task automatic step(input bit tk, input bit md, input bit up, input bit dn,
                        input logic [NF-1:0] am);
        @(negedge clk); #1;
        rst = 1'b0; tick_1hz = tk; btn_mode = md; btn_up = up; btn_down = dn; at_max = am;
        model_step(tk, md, up, dn, am);
    endtask

    task automatic do_reset(input bit md, input bit up, input bit dn);
        @(negedge clk); #1;
        rst = 1'b1; tick_1hz = 1'b0; btn_mode = md; btn_up = up; btn_down = dn; at_max = '0;
        model_reset();
        exp_q.push_back('0);
    endtask

    task automatic press_mode();
        step(1'b0, 1'b1, 1'b0, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, '0);
    endtask

    // Monitor: one registered observation per cycle against the scoreboard head.
    always @(negedge clk) begin
        cyc++;
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_a = {inc, dec, edit, sel, blink};
            checks++;
            if (mon_a !== mon_e) begin
                errors++;
                $display("FAIL outputs cyc=%0d got inc=%b dec=%b edit=%b sel=%0d blink=%b exp inc=%b dec=%b edit=%b sel=%0d blink=%b",
                         cyc, mon_a.inc, mon_a.dec, mon_a.edit, mon_a.sel, mon_a.blink,
                         mon_e.inc, mon_e.dec, mon_e.edit, mon_e.sel, mon_e.blink);
            end
        end
    end

    initial begin
        model_reset();
        do_reset(1'b0, 1'b0, 1'b0);
        idle(2);

        // Reset mid-EDIT at sel=3
        press_mode(); press_mode(); press_mode(); press_mode();
        do_reset(1'b0, 1'b0, 1'b0);
        idle(2);

        // RUN carry across two saturated fields
        step(1'b1, 1'b0, 1'b0, 1'b0, 6'b000011);
        idle(2);
        step(1'b1, 1'b0, 1'b0, 1'b0, 6'b111111);
        idle(1);

        // Enter EDIT, move to sel=2, one up, then idle ticks to timeout
        press_mode(); press_mode(); press_mode();
        step(1'b0, 1'b0, 1'b1, 1'b0, '0);
        idle(1);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, '0);
            idle(1);
        end
        idle(2);

        // Held down on sel=1 for 20 cycles
        press_mode(); press_mode();
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, 1'b1, '0);
        idle(6);

        // Simultaneous up/down, then mode with up
        step(1'b0, 1'b0, 1'b1, 1'b1, '0);
        idle(1);
        step(1'b0, 1'b1, 1'b1, 1'b0, '0);
        idle(1);

        // Walk to sel=5, exit, then a tick increments seconds
        press_mode(); press_mode(); press_mode();
        press_mode();
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        idle(2);

        // Mode held through reset gives no edge until released
        do_reset(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, '0);
        step(1'b0, 1'b1, 1'b0, 1'b0, '0);
        idle(1);
        press_mode();
        do_reset(1'b0, 1'b0, 1'b0);

        // Randomized phase
        r_md = 1'b0; r_up = 1'b0; r_dn = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            logic [NF-1:0] am;
            r_tk = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 19) == 0) r_md = !r_md;
            if ($urandom_range(0, 13) == 0) r_up = !r_up;
            if ($urandom_range(0, 13) == 0) r_dn = !r_dn;
            if ($urandom_range(0, 2) == 0) am = NF'(6'b111111 >> $urandom_range(0, 6));
            else am = NF'($urandom);
            if ($urandom_range(0, 599) == 0) do_reset(r_md, r_up, r_dn);
            else step(r_tk, r_md, r_up, r_dn, am);
        end

        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
